// File: rtl/tact_button_decoder_pkg.sv
// Shared definitions for the tact switch decoder: default switch polarity and
// the 3-bit encoding of the debounce/hold state machine.
package tact_button_decoder_pkg;

  localparam logic TACT_ON_DEFAULT = 1'b0;

  typedef enum logic [2:0] {
    ST_UP    = 3'd0,
    ST_DB_DN = 3'd1,
    ST_DOWN  = 3'd2,
    ST_LONG  = 3'd3,
    ST_DB_UP = 3'd4
  } state_e;

endpackage

// File: rtl/tact_button_decoder_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit; both stages reset to
// RST_VAL so a released switch looks idle straight out of reset.
module tact_button_decoder_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/tact_button_decoder.sv
// Tact switch conditioner: synchronise, debounce press/release and emit
// registered one-cycle press, release, long-press and auto-repeat strobes.
module tact_button_decoder
  import tact_button_decoder_pkg::*;
#(
  parameter logic TACT_ON      = TACT_ON_DEFAULT,
  parameter int   DEBOUNCE_CYC = 240000,
  parameter int   LONG_CYC     = 24000000,
  parameter int   REPEAT_CYC   = 4800000,
  parameter int   W_CNT        = 25
) (
  input  logic       CLK_24MHz,
  input  logic       RST_N,
  input  logic       TACT_IN,
  output logic       PRESSED,
  output logic       PRESS_PULSE,
  output logic       RELEASE_PULSE,
  output logic       LONG_PULSE,
  output logic       REPEAT_PULSE,
  output logic [7:0] PRESS_CNT
);

  localparam logic             TACT_OFF = ~TACT_ON;
  localparam logic [W_CNT-1:0] DB_LAST  = W_CNT'(DEBOUNCE_CYC - 1);
  localparam logic [W_CNT-1:0] LG_LAST  = W_CNT'(LONG_CYC - 1);
  localparam logic [W_CNT-1:0] RP_LAST  = W_CNT'(REPEAT_CYC - 1);

  logic             tact_sync;
  logic             s_d, s_q;
  state_e           state_d, state_q;
  logic [W_CNT-1:0] cnt_d, cnt_q;
  logic             long_flag_d, long_flag_q;
  logic             pressed_d, pressed_q;
  logic             press_p_d, press_p_q;
  logic             rel_p_d, rel_p_q;
  logic             long_p_d, long_p_q;
  logic             rep_p_d, rep_p_q;
  logic [7:0]       press_cnt_d, press_cnt_q;

  tact_button_decoder_sync_2ff #(
    .RST_VAL(TACT_OFF)
  ) u_sync (
    .clk  (CLK_24MHz),
    .rst_n(RST_N),
    .d    (TACT_IN),
    .q    (tact_sync)
  );

  // Extra register stage so the FSM sees a clean "pressed" bit one cycle later.
  assign s_d = (tact_sync == TACT_ON);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + W_CNT'(1);
    long_flag_d = long_flag_q;
    pressed_d   = pressed_q;
    press_p_d   = 1'b0;
    rel_p_d     = 1'b0;
    long_p_d    = 1'b0;
    rep_p_d     = 1'b0;
    press_cnt_d = press_cnt_q;
    unique case (state_q)
      ST_UP: begin
        cnt_d = '0;
        if (s_q) state_d = ST_DB_DN;
      end
      ST_DB_DN: begin
        if (!s_q) begin
          state_d = ST_UP;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = ST_DOWN;
          cnt_d       = '0;
          press_p_d   = 1'b1;
          pressed_d   = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end
      end
      ST_DOWN: begin
        if (!s_q) begin
          state_d = ST_DB_UP;
          cnt_d   = '0;
        end else if (cnt_q == LG_LAST) begin
          state_d     = ST_LONG;
          cnt_d       = '0;
          long_p_d    = 1'b1;
          long_flag_d = 1'b1;
        end
      end
      ST_LONG: begin
        if (!s_q) begin
          state_d = ST_DB_UP;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          rep_p_d = 1'b1;
        end
      end
      ST_DB_UP: begin
        // A bounce back to pressed resumes the hold phase with a fresh count.
        if (s_q) begin
          state_d = long_flag_q ? ST_LONG : ST_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = ST_UP;
          cnt_d       = '0;
          rel_p_d     = 1'b1;
          pressed_d   = 1'b0;
          long_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_UP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_24MHz or negedge RST_N) begin
    if (!RST_N) begin
      s_q         <= 1'b0;
      state_q     <= ST_UP;
      cnt_q       <= '0;
      long_flag_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_p_q   <= 1'b0;
      rel_p_q     <= 1'b0;
      long_p_q    <= 1'b0;
      rep_p_q     <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      s_q         <= s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_flag_q <= long_flag_d;
      pressed_q   <= pressed_d;
      press_p_q   <= press_p_d;
      rel_p_q     <= rel_p_d;
      long_p_q    <= long_p_d;
      rep_p_q     <= rep_p_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = press_p_q;
  assign RELEASE_PULSE = rel_p_q;
  assign LONG_PULSE    = long_p_q;
  assign REPEAT_PULSE  = rep_p_q;
  assign PRESS_CNT     = press_cnt_q;

endmodule

// File: tb/tb_tact_button_decoder.sv
// Bench for tact_button_decoder: per-cycle comparison against a run-length
// reference model, a table of hold lengths, and hand-written corner sequences.
module tb_tact_button_decoder;

  localparam int DB = 8;
  localparam int LG = 32;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tact;
  logic       pressed, press_p, rel_p, long_p, rep_p;
  logic [7:0] press_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tact_button_decoder #(
    .TACT_ON     (1'b0),
    .DEBOUNCE_CYC(DB),
    .LONG_CYC    (LG),
    .REPEAT_CYC  (RP),
    .W_CNT       (8)
  ) dut (
    .CLK_24MHz    (clk),
    .RST_N        (rst_n),
    .TACT_IN      (tact),
    .PRESSED      (pressed),
    .PRESS_PULSE  (press_p),
    .RELEASE_PULSE(rel_p),
    .LONG_PULSE   (long_p),
    .REPEAT_PULSE (rep_p),
    .PRESS_CNT    (press_cnt)
  );

  // Reference model: s arrives three clocks after the raw sample; a level is
  // accepted after DB+1 consecutive opposite samples; hold timing uses the
  // length of the current unbroken run of pressed samples.
  bit [2:0]  m_pipe;
  bit        m_lvl, m_lf;
  int        m_run, m_h;
  bit        m_pp, m_rp, m_lp, m_rpp;
  bit [7:0]  m_cnt;

  int c_press, c_rel, c_long, c_rep;

  task automatic model_reset();
    m_pipe = '0; m_lvl = 0; m_lf = 0; m_run = 0; m_h = 0;
    m_pp = 0; m_rp = 0; m_lp = 0; m_rpp = 0; m_cnt = 8'd0;
  endtask

  task automatic model_step(input logic raw);
    bit s;
    s = m_pipe[2];
    m_pipe = {m_pipe[1:0], (raw == 1'b0)};
    m_pp = 0; m_rp = 0; m_lp = 0; m_rpp = 0;
    m_run = (s != m_lvl) ? m_run + 1 : 0;
    if (m_lvl) m_h = s ? m_h + 1 : 0;
    if (m_run == DB + 1) begin
      m_lvl = s;
      m_run = 0;
      if (s) begin
        m_pp = 1; m_cnt = m_cnt + 8'd1; m_h = 1;
      end else begin
        m_rp = 1; m_lf = 0; m_h = 0;
      end
    end else if (m_lvl && s) begin
      if (!m_lf && m_h == LG + 1) begin
        m_lp = 1; m_lf = 1; m_h = 1;
      end else if (m_lf && m_h == RP + 1) begin
        m_rpp = 1; m_h = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string name);
    check(name, {19'd0, pressed, press_p, rel_p, long_p, rep_p, press_cnt},
          {19'd0, m_lvl, m_pp, m_rp, m_lp, m_rpp, m_cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(tact);
    @(negedge clk);
    compare_outputs("cycle");
    c_press += int'(press_p);
    c_rel   += int'(rel_p);
    c_long  += int'(long_p);
    c_rep   += int'(rep_p);
  endtask

  task automatic clear_counts();
    c_press = 0; c_rel = 0; c_long = 0; c_rep = 0;
  endtask

  // which: 0 press, 1 release, 2 repeat. lat = edges after the first sampling edge.
  task automatic wait_for(input int which, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((which == 0 && press_p) || (which == 1 && rel_p) || (which == 2 && rep_p)) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("async_reset");
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int low;
    int high;
    int e_press;
    int e_rel;
    int e_long;
    int e_rep;
  } vec_t;

  initial begin
    vec_t vt[9];
    int   lat;
    int   exp_cnt;

    vt[0] = '{60,  20, 1, 1, 1, 2};
    vt[1] = '{5,   20, 0, 0, 0, 0};
    vt[2] = '{8,   20, 0, 0, 0, 0};
    vt[3] = '{9,   20, 1, 1, 0, 0};
    vt[4] = '{40,  30, 1, 1, 0, 0};
    vt[5] = '{41,  30, 1, 1, 1, 0};
    vt[6] = '{48,  30, 1, 1, 1, 0};
    vt[7] = '{49,  30, 1, 1, 1, 1};
    vt[8] = '{123, 20, 1, 1, 1, 10};

    rst_n = 1'b0;
    tact  = 1'b1;
    model_reset();
    clear_counts();
    repeat (3) tick();
    check("reset_state", {24'd0, pressed, press_p, rel_p, long_p, rep_p, 3'd0} | {24'd0, press_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      clear_counts();
      tact = 1'b0;
      repeat (vt[i].low) tick();
      tact = 1'b1;
      repeat (vt[i].high) tick();
      exp_cnt += vt[i].e_press;
      check($sformatf("v%0d_press", i), c_press, vt[i].e_press);
      check($sformatf("v%0d_release", i), c_rel, vt[i].e_rel);
      check($sformatf("v%0d_long", i), c_long, vt[i].e_long);
      check($sformatf("v%0d_repeat", i), c_rep, vt[i].e_rep);
      check($sformatf("v%0d_cnt", i), press_cnt, exp_cnt);
      check($sformatf("v%0d_level", i), pressed, 0);
    end

    // Bounce on press: four toggles two cycles apart, then steady pressed.
    clear_counts();
    tact = 1'b0; repeat (2) tick();
    tact = 1'b1; repeat (2) tick();
    tact = 1'b0; repeat (2) tick();
    tact = 1'b1; repeat (2) tick();
    tact = 1'b0;
    wait_for(0, 40, lat);
    check("bounce_press_latency", lat, 11);
    repeat (10) tick();
    tact = 1'b1; repeat (2) tick();
    tact = 1'b0; repeat (2) tick();
    tact = 1'b1; repeat (2) tick();
    tact = 1'b0; repeat (2) tick();
    tact = 1'b1;
    wait_for(1, 40, lat);
    check("bounce_release_latency", lat, 11);
    check("bounce_press_count", c_press, 1);
    check("bounce_release_count", c_rel, 1);
    check("bounce_long_count", c_long, 0);
    repeat (5) tick();

    // Release glitch while in long-press.
    tact = 1'b0;
    wait_for(0, 30, lat);
    check("long_press_latency", lat, 11);
    wait_for(2, 60, lat);
    wait_for(2, 20, lat);
    check("repeat_period", lat, 7);
    clear_counts();
    tact = 1'b1; repeat (3) tick();
    tact = 1'b0;
    wait_for(2, 30, lat);
    check("repeat_after_glitch", lat, 11);
    check("glitch_no_release", c_rel, 0);
    check("glitch_level", pressed, 1);
    clear_counts();
    tact = 1'b1;
    wait_for(1, 30, lat);
    check("long_release_latency", lat, 11);
    check("no_repeat_on_release", c_rep, 0);
    repeat (5) tick();

    // Reset while pressed, switch held through reset release.
    tact = 1'b0;
    wait_for(0, 30, lat);
    check("pre_reset_press", pressed, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_drops_level", pressed, 0);
    check("reset_drops_cnt", press_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_for(0, 30, lat);
    check("held_through_reset", lat, 11);
    tact = 1'b1;
    repeat (20) tick();

    // 256 presses wrap the counter back to zero.
    async_reset();
    for (int n = 0; n < 256; n++) begin
      tact = 1'b0; repeat (12) tick();
      tact = 1'b1; repeat (14) tick();
      if (n == 254) check("cnt_255", press_cnt, 255);
    end
    check("cnt_wrap", press_cnt, 0);

    // Random stimulus against the model.
    for (int seg = 0; seg < 200; seg++) begin
      int dur;
      if ($urandom_range(0, 49) == 0) async_reset();
      tact = 1'($urandom_range(0, 1));
      dur  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 12));
      repeat (dur) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
